// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI sequencers: state encodings and parameter helpers.
// The legality check is a function so both sequencers can use it from a generate block.
package spi_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SETUP = 3'd3,
      ST_SHIFT = 3'd4,
      ST_STALL = 3'd5,
      ST_HOLD  = 3'd6,
      ST_GAP   = 3'd7
   } seq_state_e;

   function automatic bit seq_params_ok(input int unsigned data_w, input int unsigned frame_bytes,
                                        input int unsigned cs_setup, input int unsigned cs_hold,
                                        input int unsigned gap);
      return (data_w >= 2) && (frame_bytes >= 1) && (cs_setup >= 1) && (cs_hold >= 1) && (gap >= 1);
   endfunction

   // Timer holds (cycles - 1), so it needs to reach the largest delay minus one.
   function automatic int unsigned seq_timer_w(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable down-counter shared by the chip-select setup, hold and inter-frame gap phases.
// done is high while the count is zero; a load of N keeps done low for N cycles.
module spi_seq_timer #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             spi_clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge spi_clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/spi_tx_sequencer.sv
// FIFO read-side SPI mode-0 transmitter: pops bytes, frames them under cs_n and shifts MSB first.
// Every output is registered from the next-state decode, so outputs follow the state with no glitches.
module spi_tx_sequencer
   import spi_seq_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned FRAME_BYTES = 4,
   parameter int unsigned CS_SETUP    = 1,
   parameter int unsigned CS_HOLD     = 1,
   parameter int unsigned GAP         = 2
) (
   input  logic              spi_clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_e,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              spi_cs_n,
   output logic              spi_sck,
   output logic              spi_mosi,
   output logic              busy,
   output logic              frame_done,
   output logic              underrun
);

   localparam int unsigned BIT_W  = $clog2(2 * DATA_W);
   localparam int unsigned BYTE_W = $clog2(FRAME_BYTES + 1);
   localparam int unsigned TMR_W  = seq_timer_w(CS_SETUP, CS_HOLD, GAP);
   localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(2 * DATA_W - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(FRAME_BYTES);
   localparam logic [TMR_W-1:0]  SETUP_LOAD = TMR_W'(CS_SETUP - 1);
   localparam logic [TMR_W-1:0]  HOLD_LOAD  = TMR_W'(CS_HOLD - 1);
   localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(GAP - 1);

   if (!seq_params_ok(DATA_W, FRAME_BYTES, CS_SETUP, CS_HOLD, GAP)) begin : g_param_check
      $error("spi_tx_sequencer: illegal parameter set");
   end

   seq_state_e        state, state_nxt;
   logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [BYTE_W-1:0] byte_cnt, byte_cnt_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;
   logic              mosi_nxt;
   logic              tmr_load, tmr_done;
   logic [TMR_W-1:0]  tmr_val;
   logic              rx_ready_nxt, cs_n_nxt, sck_nxt, busy_nxt, frame_done_nxt, underrun_nxt;

   spi_seq_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .spi_clk  (spi_clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      byte_cnt_nxt = byte_cnt;
      shreg_nxt    = shreg;
      mosi_nxt     = spi_mosi;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      case (state)
         ST_IDLE: begin
            if (enable && !fifo_e) state_nxt = ST_POP;
         end
         ST_POP: begin
            state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            shreg_nxt   = rx_data;
            mosi_nxt    = rx_data[DATA_W-1];
            bit_cnt_nxt = '0;
            if (byte_cnt == '0) begin
               state_nxt = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_val   = SETUP_LOAD;
            end else begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_SETUP: begin
            if (tmr_done) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            // Even count means sck is high now, so the coming edge is a fall.
            if (!bit_cnt[0]) begin
               shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
               mosi_nxt  = shreg[DATA_W-2];
            end
            if (bit_cnt == BIT_LAST) begin
               bit_cnt_nxt  = '0;
               byte_cnt_nxt = byte_cnt + 1'b1;
               if (byte_cnt_nxt == BYTE_LAST) begin
                  state_nxt = ST_HOLD;
                  tmr_load  = 1'b1;
                  tmr_val   = HOLD_LOAD;
               end else if (!fifo_e) begin
                  state_nxt = ST_POP;
               end else begin
                  state_nxt = ST_STALL;
               end
            end
         end
         ST_STALL: begin
            if (!fifo_e) state_nxt = ST_POP;
         end
         ST_HOLD: begin
            if (tmr_done) begin
               state_nxt = ST_GAP;
               tmr_load  = 1'b1;
               tmr_val   = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (tmr_done) begin
               state_nxt    = ST_IDLE;
               byte_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      rx_ready_nxt   = (state_nxt == ST_POP);
      sck_nxt        = (state_nxt == ST_SHIFT) && !bit_cnt_nxt[0];
      busy_nxt       = (state_nxt != ST_IDLE);
      frame_done_nxt = (state == ST_HOLD) && (state_nxt == ST_GAP);
      underrun_nxt   = (state_nxt == ST_STALL) && (state != ST_STALL);
      case (state_nxt)
         ST_IDLE, ST_GAP: cs_n_nxt = 1'b1;
         ST_POP, ST_LOAD: cs_n_nxt = (byte_cnt_nxt == '0);
         default:         cs_n_nxt = 1'b0;
      endcase
   end

   // Registered state, counters and outputs
   always_ff @(posedge spi_clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         rx_ready   <= 1'b0;
         spi_cs_n   <= 1'b1;
         spi_sck    <= 1'b0;
         spi_mosi   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         byte_cnt   <= byte_cnt_nxt;
         rx_ready   <= rx_ready_nxt;
         spi_cs_n   <= cs_n_nxt;
         spi_sck    <= sck_nxt;
         spi_mosi   <= mosi_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
         underrun   <= underrun_nxt;
      end
   end

   always_ff @(posedge spi_clk) begin
      shreg <= shreg_nxt;
   end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer: a FIFO model feeds bytes and a monitor decodes the SPI side.
// Each scenario task drives stimulus and compares against hand-derived values.
module tb_spi_tx_sequencer;

   localparam int GAP      = 2;
   localparam int CS_SETUP = 1;
   localparam logic [31:0] T1_BYTES = 32'hA53CFF00;
   localparam logic [31:0] T3_BYTES = 32'h11223344;
   localparam logic [63:0] T4_BYTES = 64'h5152535455565758;
   localparam logic [31:0] T5_BYTES = 32'h63646566;
   localparam logic [63:0] T6_BYTES = 64'h7172737475767778;

   logic       spi_clk = 1'b0;
   logic       rst     = 1'b1;
   logic       enable  = 1'b0;
   logic       fifo_e;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ready, spi_cs_n, spi_sck, spi_mosi, busy, frame_done, underrun;

   int n_tests = 0;
   int n_fail  = 0;

   spi_tx_sequencer #(
      .DATA_W      (8),
      .FRAME_BYTES (4),
      .CS_SETUP    (CS_SETUP),
      .CS_HOLD     (1),
      .GAP         (GAP)
   ) dut (
      .spi_clk    (spi_clk),
      .rst        (rst),
      .enable     (enable),
      .fifo_e     (fifo_e),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .spi_cs_n   (spi_cs_n),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   always #5 spi_clk = ~spi_clk;

   // FIFO model: data appears on rx_data the cycle after rx_ready
   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_e = (wr_ptr == rd_ptr);

   always @(posedge spi_clk) begin
      if (rx_ready) begin
         rx_data <= mem[rd_ptr[7:0]];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   // SPI-side monitor, sampled on the falling edge of spi_clk
   logic [7:0] cap_mem [0:255];
   logic [7:0] cur = 8'h00;
   int cap_n = 0, bit_n = 0, rises = 0;
   int rr_cnt = 0, rr_wide = 0, rr_empty = 0, fd_cnt = 0, ur_cnt = 0, sck_no_cs = 0;
   int cs_low_cnt = 0, setup_len = 0, csn_high_cnt = 0, last_csn_high = 0;
   int idle_cnt = 0, last_idle = 0, gap_cnt = 0, last_gap = 0;
   logic sck_prev = 1'b0, rr_prev = 1'b0, cs_prev = 1'b1, busy_prev = 1'b0;
   logic first_pend = 1'b1, in_gap = 1'b0;

   always @(negedge spi_clk) begin
      sck_prev  <= spi_sck;
      rr_prev   <= rx_ready;
      cs_prev   <= spi_cs_n;
      busy_prev <= busy;
      if (rx_ready) rr_cnt <= rr_cnt + 1;
      if (rx_ready && rr_prev) rr_wide <= rr_wide + 1;
      if (rx_ready && fifo_e) rr_empty <= rr_empty + 1;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (underrun) ur_cnt <= ur_cnt + 1;
      if (spi_sck && spi_cs_n) sck_no_cs <= sck_no_cs + 1;
      if (spi_cs_n) begin
         bit_n        <= 0;
         cs_low_cnt   <= 0;
         first_pend   <= 1'b1;
         csn_high_cnt <= csn_high_cnt + 1;
      end else begin
         cs_low_cnt   <= cs_low_cnt + 1;
         csn_high_cnt <= 0;
         if (cs_prev) last_csn_high <= csn_high_cnt;
         if (spi_sck && !sck_prev) begin
            rises <= rises + 1;
            cur   <= {cur[6:0], spi_mosi};
            if (first_pend) begin
               setup_len  <= cs_low_cnt;
               first_pend <= 1'b0;
            end
            if (bit_n == 7) begin
               cap_mem[cap_n[7:0]] <= {cur[6:0], spi_mosi};
               cap_n <= cap_n + 1;
               bit_n <= 0;
            end else begin
               bit_n <= bit_n + 1;
            end
         end
      end
      if (!busy) begin
         idle_cnt <= idle_cnt + 1;
      end else begin
         if (!busy_prev) last_idle <= idle_cnt;
         idle_cnt <= 0;
      end
      if (frame_done) begin
         gap_cnt <= 1;
         in_gap  <= 1'b1;
      end else if (in_gap) begin
         if (busy && spi_cs_n) begin
            gap_cnt <= gap_cnt + 1;
         end else begin
            last_gap <= gap_cnt;
            in_gap   <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(negedge spi_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_fd(input int target, input int budget, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         if (fd_cnt >= target) ok = 1'b1;
         else begin
            tick();
            n++;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         if (!busy) ok = 1'b1;
         else begin
            tick();
            n++;
         end
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      enable = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({rx_ready, spi_cs_n, spi_sck, spi_mosi} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_io: got ready/cs_n/sck/mosi=%b expected 0100",
                  {rx_ready, spi_cs_n, spi_sck, spi_mosi});
      end
      n_tests++;
      if ({busy, frame_done, underrun} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_status: got busy/done/underrun=%b expected 000",
                  {busy, frame_done, underrun});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_frame();
      int b_cap, b_fd, b_rise, b_rr;
      bit ok, ok2;
      b_cap = cap_n; b_fd = fd_cnt; b_rise = rises; b_rr = rr_cnt;
      push(8'hA5); push(8'h3C); push(8'hFF); push(8'h00);
      enable = 1'b1;
      wait_fd(b_fd + 1, 300, ok);
      wait_idle(50, ok2);
      n_tests++;
      if (!(ok && ok2)) begin
         n_fail++;
         $display("FAIL frame_timeout: got done/idle=%0b%0b expected 11", ok, ok2);
      end
      n_tests++;
      if (cap_n - b_cap !== 4) begin
         n_fail++;
         $display("FAIL frame_count: got %0d bytes expected 4", cap_n - b_cap);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (cap_mem[b_cap + i] !== T1_BYTES[31-8*i -: 8]) begin
            n_fail++;
            $display("FAIL frame_byte%0d: got %h expected %h", i, cap_mem[b_cap + i],
                     T1_BYTES[31-8*i -: 8]);
         end
      end
      n_tests++;
      if (rises - b_rise !== 32) begin
         n_fail++;
         $display("FAIL frame_rises: got %0d expected 32", rises - b_rise);
      end
      n_tests++;
      if (rr_cnt - b_rr !== 4) begin
         n_fail++;
         $display("FAIL frame_pops: got %0d expected 4", rr_cnt - b_rr);
      end
      n_tests++;
      if ({rr_wide, rr_empty} !== {32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL frame_pop_shape: got wide=%0d empty=%0d expected 0 0", rr_wide, rr_empty);
      end
      n_tests++;
      if (fd_cnt - b_fd !== 1) begin
         n_fail++;
         $display("FAIL frame_done_cnt: got %0d expected 1", fd_cnt - b_fd);
      end
      n_tests++;
      if (setup_len !== CS_SETUP) begin
         n_fail++;
         $display("FAIL frame_setup: got %0d expected %0d", setup_len, CS_SETUP);
      end
      n_tests++;
      if (last_gap !== GAP) begin
         n_fail++;
         $display("FAIL frame_gap: got %0d expected %0d", last_gap, GAP);
      end
      n_tests++;
      if (sck_no_cs !== 0) begin
         n_fail++;
         $display("FAIL frame_sck_cs: got %0d sck-high cycles with cs_n high expected 0", sck_no_cs);
      end
   endtask

   task automatic test_underrun();
      int b_cap, b_fd, b_ur, stall_bad, n;
      bit ok, ok2;
      b_cap = cap_n; b_fd = fd_cnt; b_ur = ur_cnt; stall_bad = 0;
      push(8'h11); push(8'h22);
      n = 0;
      while (n < 200 && ur_cnt == b_ur) begin
         tick();
         n++;
      end
      n_tests++;
      if (ur_cnt == b_ur) begin
         n_fail++;
         $display("FAIL underrun_seen: got no underrun pulse expected 1");
      end
      repeat (20) begin
         tick();
         if (spi_cs_n !== 1'b0 || spi_sck !== 1'b0 || rx_ready !== 1'b0) stall_bad++;
      end
      push(8'h33); push(8'h44);
      wait_fd(b_fd + 1, 300, ok);
      wait_idle(50, ok2);
      n_tests++;
      if (stall_bad !== 0) begin
         n_fail++;
         $display("FAIL underrun_stall: got %0d bad stall cycles expected 0", stall_bad);
      end
      n_tests++;
      if (ur_cnt - b_ur !== 1) begin
         n_fail++;
         $display("FAIL underrun_pulses: got %0d expected 1", ur_cnt - b_ur);
      end
      n_tests++;
      if (!(ok && ok2) || cap_n - b_cap !== 4) begin
         n_fail++;
         $display("FAIL underrun_frame: got %0d bytes done=%0b expected 4 bytes done=1",
                  cap_n - b_cap, ok);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (cap_mem[b_cap + i] !== T3_BYTES[31-8*i -: 8]) begin
            n_fail++;
            $display("FAIL underrun_byte%0d: got %h expected %h", i, cap_mem[b_cap + i],
                     T3_BYTES[31-8*i -: 8]);
         end
      end
   endtask

   task automatic test_enable_drop();
      int b_cap, b_fd, busy_seen, n;
      bit ok, ok2;
      enable = 1'b0;
      b_cap = cap_n; b_fd = fd_cnt; busy_seen = 0;
      for (int i = 0; i < 8; i++) push(T4_BYTES[63-8*i -: 8]);
      enable = 1'b1;
      n = 0;
      while (n < 100 && cap_n < b_cap + 1) begin
         tick();
         n++;
      end
      enable = 1'b0;
      wait_fd(b_fd + 1, 300, ok);
      wait_idle(50, ok2);
      repeat (60) begin
         tick();
         if (busy) busy_seen++;
      end
      n_tests++;
      if (!(ok && ok2) || busy_seen !== 0) begin
         n_fail++;
         $display("FAIL endrop_hold: got done=%0b busy_cycles=%0d expected done=1 busy_cycles=0",
                  ok, busy_seen);
      end
      n_tests++;
      if (wr_ptr - rd_ptr !== 4) begin
         n_fail++;
         $display("FAIL endrop_level: got %0d bytes left expected 4", wr_ptr - rd_ptr);
      end
      enable = 1'b1;
      wait_fd(b_fd + 2, 300, ok);
      wait_idle(50, ok2);
      n_tests++;
      if (!(ok && ok2) || cap_n - b_cap !== 8) begin
         n_fail++;
         $display("FAIL endrop_count: got %0d bytes expected 8", cap_n - b_cap);
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (cap_mem[b_cap + i] !== T4_BYTES[63-8*i -: 8]) begin
            n_fail++;
            $display("FAIL endrop_byte%0d: got %h expected %h", i, cap_mem[b_cap + i],
                     T4_BYTES[63-8*i -: 8]);
         end
      end
   endtask

   task automatic test_reset_abort();
      int b_cap, b_fd, n;
      bit ok, ok2;
      b_cap = cap_n; b_fd = fd_cnt;
      push(8'h61); push(8'h62); push(8'h63); push(8'h64); push(8'h65); push(8'h66);
      n = 0;
      while (n < 100 && !(cap_n == b_cap + 1 && bit_n == 3)) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if ({spi_cs_n, spi_sck, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL abort_outputs: got cs_n/sck/busy=%b expected 100", {spi_cs_n, spi_sck, busy});
      end
      rst = 1'b0;
      wait_fd(b_fd + 1, 300, ok);
      wait_idle(50, ok2);
      n_tests++;
      if (!(ok && ok2) || cap_n - b_cap !== 5) begin
         n_fail++;
         $display("FAIL abort_count: got %0d bytes expected 5", cap_n - b_cap);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (cap_mem[b_cap + 1 + i] !== T5_BYTES[31-8*i -: 8]) begin
            n_fail++;
            $display("FAIL abort_byte%0d: got %h expected %h", i, cap_mem[b_cap + 1 + i],
                     T5_BYTES[31-8*i -: 8]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int b_cap, b_fd;
      bit ok, ok2;
      b_cap = cap_n; b_fd = fd_cnt;
      for (int i = 0; i < 8; i++) push(T6_BYTES[63-8*i -: 8]);
      wait_fd(b_fd + 2, 500, ok);
      wait_idle(50, ok2);
      n_tests++;
      if (!(ok && ok2) || cap_n - b_cap !== 8) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d bytes expected 8", cap_n - b_cap);
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (cap_mem[b_cap + i] !== T6_BYTES[63-8*i -: 8]) begin
            n_fail++;
            $display("FAIL b2b_byte%0d: got %h expected %h", i, cap_mem[b_cap + i],
                     T6_BYTES[63-8*i -: 8]);
         end
      end
      n_tests++;
      if (last_gap !== GAP) begin
         n_fail++;
         $display("FAIL b2b_gap: got %0d expected %0d", last_gap, GAP);
      end
      n_tests++;
      if (last_idle !== 1) begin
         n_fail++;
         $display("FAIL b2b_idle: got %0d busy-low cycles expected 1", last_idle);
      end
      // cs_n stays high through GAP, the single IDLE cycle and the first POP/LOAD
      n_tests++;
      if (last_csn_high !== GAP + 3) begin
         n_fail++;
         $display("FAIL b2b_cs_high: got %0d expected %0d", last_csn_high, GAP + 3);
      end
      n_tests++;
      if ({rr_wide, rr_empty} !== {32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL b2b_pop_shape: got wide=%0d empty=%0d expected 0 0", rr_wide, rr_empty);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_underrun();
      test_enable_drop();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
